m68k_device_mux: RTL and testbench
==================================

# m68k_device_mux

Address decoder and data/handshake router between the single 68000-style bus master (TG68 CPU) and three slaves: boot memory/SRAM (slave1), UART (slave2) and LED register (slave3). It steers byte strobes to exactly one slave, returns that slave's read data and acknowledge to the master, and terminates accesses to unmapped or unresponsive addresses itself so the CPU never hangs.

## Interface
Parameters:
- TIMEOUT, 255: cycles a selected slave may withhold ack before the mux terminates the cycle itself.

Ports:
- clk  in  1  system clock; all state on rising edge.
- reset_n  in  1  reset, asynchronous and active-high (asserted when 1), despite the codebase name.
- master_write  in  16  write data from CPU.
- master_read  out  16  read data to CPU.
- master_addr  in  32  byte address from CPU; bits [31:24] ignored.
- master_uds  in  1  upper byte strobe, active-high (data[15:8], even address).
- master_lds  in  1  lower byte strobe, active-high (data[7:0], odd address).
- master_ack  out  1  cycle acknowledge, active-high (CPU dtack = ~master_ack).
- slaveN_write  out  16  (N=1,2,3) write data to slave N.
- slaveN_read  in  16  read data from slave N.
- slave1_addr  out  24; slave2_addr, slave3_addr  out  8  slave byte addresses.
- slaveN_uds, slaveN_lds  out  1  gated byte strobes, active-high.
- slaveN_ack  in  1  slave acknowledge, active-high.

## Operation
- Bus cycle active = master_uds | master_lds.
- Decode on master_addr[23:0] (combinational):
  - 0x000000–0xEFFFFF → slave1; slave1_addr = master_addr[23:0].
  - 0xF00000–0xF000FF → slave2; slave2_addr = master_addr[7:0].
  - 0xF00100–0xF001FF → slave3; slave3_addr = master_addr[7:0].
  - any other 0xFxxxxx → unmapped.
- slaveN_addr and slaveN_write are driven from master signals unconditionally (broadcast).
- Strobes: selected slave gets master_uds/master_lds; unselected slaves get 0. Unmapped: all slave strobes 0.
- master_read = selected slave's read data; 0xFFFF when unmapped or during a timeout termination.
- master_ack = selected slave's ack AND cycle active, OR internal termination ack. Slave acks from unselected slaves or while idle are ignored.
- Internal termination ack (registered, ack_int):
  - Unmapped: set on the first rising edge where cycle is active.
  - Mapped: wait counter increments each cycle while active and selected slave ack = 0; when it reaches TIMEOUT, ack_int sets.
  - ack_int and counter clear on the first edge where cycle is inactive; counter also clears when slave ack is seen.
- Writes to unmapped/timed-out addresses are discarded (no slave strobed, or slave unacked).

## Timing
- Reset: ack_int=0, counter=0; so master_ack=0. Combinational outputs follow inputs during reset, except master_ack forced to 0.
- Slave path: zero-cycle latency; master_ack rises in the same cycle as the slave's ack.
- Unmapped path: master_ack rises 1 cycle after strobe assertion; stays high until strobes fall, deasserts combinationally then (ack_int register clears next edge, but is masked by inactive cycle).
- Timeout path: master_ack rises TIMEOUT+1 edges after strobe assertion if no slave ack.
- Address change while strobes stay high: decode follows new address immediately; counter not reset (master must drop strobes between cycles).
- Reset asserted mid-cycle: master_ack drops immediately, counter cleared.

## Test plan
- Read 0x000100, uds=lds=1, slave1_read=0x4E71, slave1 ack after 3 cycles -> only slave1 strobes high, slave1_addr=0x000100, master_ack high on cycle 3, master_read=0x4E71.
- Byte write 0xF00003, lds only, data 0x0041 -> slave2_lds=1, slave2_uds=0, slave2_addr=0x03, slave2_write=0x0041, slave1/3 strobes 0.
- Read 0xF00100 with slave3_read=0x00A5, ack immediate -> master_ack same cycle, master_read=0x00A5.
- Read 0xF80000 -> no slave strobed, master_ack 1 cycle later, master_read=0xFFFF; ack drops when strobes drop.
- Read 0x001000 with slave1 never acking -> master_ack after 256 edges, master_read=0xFFFF.
- Assert reset_n=1 during pending cycle -> master_ack=0 at once; after release, new cycle behaves normally; spurious slave2_ack while idle -> master_ack stays 0.

Source files
------------

// File: rtl/m68k_device_mux_if.sv
// Bus bundle between the 68000-style master, the device mux and its three slaves.
// The mux takes the 'slave' view (it answers the CPU); the environment takes 'master'.
interface m68k_device_mux_if;
  logic [15:0] master_write;
  logic [15:0] master_read;
  logic [31:0] master_addr;
  logic        master_uds;
  logic        master_lds;
  logic        master_ack;

  logic [15:0] slave1_write, slave2_write, slave3_write;
  logic [15:0] slave1_read, slave2_read, slave3_read;
  logic [23:0] slave1_addr;
  logic [7:0]  slave2_addr, slave3_addr;
  logic        slave1_uds, slave2_uds, slave3_uds;
  logic        slave1_lds, slave2_lds, slave3_lds;
  logic        slave1_ack, slave2_ack, slave3_ack;

  modport slave (
    input  master_write, master_addr, master_uds, master_lds,
    output master_read, master_ack,
    output slave1_write, slave2_write, slave3_write,
    input  slave1_read, slave2_read, slave3_read,
    output slave1_addr, slave2_addr, slave3_addr,
    output slave1_uds, slave2_uds, slave3_uds,
    output slave1_lds, slave2_lds, slave3_lds,
    input  slave1_ack, slave2_ack, slave3_ack
  );

  modport master (
    output master_write, master_addr, master_uds, master_lds,
    input  master_read, master_ack,
    input  slave1_write, slave2_write, slave3_write,
    output slave1_read, slave2_read, slave3_read,
    input  slave1_addr, slave2_addr, slave3_addr,
    input  slave1_uds, slave2_uds, slave3_uds,
    input  slave1_lds, slave2_lds, slave3_lds,
    output slave1_ack, slave2_ack, slave3_ack
  );
endinterface

// File: rtl/m68k_device_mux.sv
// Address decode and ack/data routing from one 68000 master to SRAM, UART and LED slaves.
// Slave path is zero-latency; unmapped or silent slaves are terminated internally (0xFFFF).
module m68k_device_mux #(
  parameter int TIMEOUT = 255
) (
  input logic              clk,
  input logic              reset_n,
  m68k_device_mux_if.slave bus
);
  localparam int CW = $clog2(TIMEOUT + 1);

  // reset_n keeps its legacy name but is active-high
  logic rst;
  assign rst = reset_n;

  logic          active;
  logic          sel1, sel2, sel3, unmapped;
  logic          sel_ack;
  logic          ack_int;
  logic [CW-1:0] wait_cnt;
  logic          unused_hi;

  assign unused_hi = &{1'b0, bus.master_addr[31:24]};

  assign active   = bus.master_uds | bus.master_lds;
  assign sel1     = (bus.master_addr[23:20] != 4'hF);
  assign sel2     = (bus.master_addr[23:8] == 16'hF000);
  assign sel3     = (bus.master_addr[23:8] == 16'hF001);
  assign unmapped = ~(sel1 | sel2 | sel3);

  assign sel_ack = (sel1 & bus.slave1_ack) | (sel2 & bus.slave2_ack) | (sel3 & bus.slave3_ack);

  assign bus.slave1_addr  = bus.master_addr[23:0];
  assign bus.slave2_addr  = bus.master_addr[7:0];
  assign bus.slave3_addr  = bus.master_addr[7:0];
  assign bus.slave1_write = bus.master_write;
  assign bus.slave2_write = bus.master_write;
  assign bus.slave3_write = bus.master_write;

  assign bus.slave1_uds = sel1 & bus.master_uds;
  assign bus.slave1_lds = sel1 & bus.master_lds;
  assign bus.slave2_uds = sel2 & bus.master_uds;
  assign bus.slave2_lds = sel2 & bus.master_lds;
  assign bus.slave3_uds = sel3 & bus.master_uds;
  assign bus.slave3_lds = sel3 & bus.master_lds;

  always_comb begin
    bus.master_read = 16'hFFFF;
    if (!ack_int) begin
      if (sel1)      bus.master_read = bus.slave1_read;
      else if (sel2) bus.master_read = bus.slave2_read;
      else if (sel3) bus.master_read = bus.slave3_read;
    end
  end

  // ack_int only counts inside an active cycle, so a stale register cannot leak out
  assign bus.master_ack = ~rst & active & (sel_ack | ack_int);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack_int  <= 1'b0;
      wait_cnt <= '0;
    end else if (!active) begin
      ack_int  <= 1'b0;
      wait_cnt <= '0;
    end else if (unmapped) begin
      ack_int <= 1'b1;
    end else if (sel_ack) begin
      wait_cnt <= '0;
    end else if (wait_cnt == CW'(TIMEOUT)) begin
      ack_int <= 1'b1;
    end else begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_m68k_device_mux.sv
// Scoreboard bench for m68k_device_mux: expected read data and ack latency queued per cycle.
module tb_m68k_device_mux;
  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  m68k_device_mux_if bus ();
  m68k_device_mux #(.TIMEOUT(255)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  typedef struct {
    logic [15:0] rd;
    int          lat;
  } exp_t;
  exp_t sb_q[$];

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  task automatic set_ack(input logic [2:0] sel, input logic v);
    if (sel[0]) bus.slave1_ack = v;
    if (sel[1]) bus.slave2_ack = v;
    if (sel[2]) bus.slave3_ack = v;
  endtask

  // Wait (bounded) for master_ack; returns edges elapsed since strobes went up
  task automatic wait_ack(input int ack_dly, input logic [2:0] sel, output int n, output logic seen);
    n = 0;
    seen = 1'b0;
    while (!seen && n < 400) begin
      if (bus.master_ack) seen = 1'b1;
      else begin
        @(posedge clk); #1;
        n++;
        if (n == ack_dly) begin set_ack(sel, 1'b1); #1; end
      end
    end
  endtask

  task automatic drop_cycle(input string tag);
    @(negedge clk);
    bus.master_uds = 1'b0;
    bus.master_lds = 1'b0;
    set_ack(3'b111, 1'b0);
    #1 check({tag, "_ackdrop"}, bus.master_ack, 1'b0);
    @(posedge clk); #1;
  endtask

  task automatic run_cycle(input string tag, input logic [31:0] addr, input logic uds, input logic lds,
                           input logic [15:0] wdat, input int ack_dly, input logic [2:0] sel,
                           input logic [15:0] exp_rd, input int exp_lat);
    int   n;
    logic seen;
    exp_t e;
    logic [5:0] exp_stb, got_stb;
    sb_q.push_back('{rd: exp_rd, lat: exp_lat});
    @(negedge clk);
    bus.master_addr  = addr;
    bus.master_write = wdat;
    bus.master_uds   = uds;
    bus.master_lds   = lds;
    if (ack_dly == 0) set_ack(sel, 1'b1);
    #1;
    exp_stb = {sel[2] ? {uds, lds} : 2'b00, sel[1] ? {uds, lds} : 2'b00, sel[0] ? {uds, lds} : 2'b00};
    got_stb = {bus.slave3_uds, bus.slave3_lds, bus.slave2_uds, bus.slave2_lds, bus.slave1_uds, bus.slave1_lds};
    check({tag, "_strobes"}, got_stb, exp_stb);
    check({tag, "_s1addr"}, bus.slave1_addr, addr[23:0]);
    check({tag, "_s2addr"}, bus.slave2_addr, addr[7:0]);
    check({tag, "_s3wr"}, bus.slave3_write, wdat);
    wait_ack(ack_dly, sel, n, seen);
    check({tag, "_ackseen"}, seen, 1'b1);
    e = sb_q.pop_front();
    check({tag, "_lat"}, n, e.lat);
    check({tag, "_rd"}, bus.master_read, e.rd);
    drop_cycle(tag);
  endtask

  initial begin
    int   n;
    logic seen;
    exp_t e;
    reset_n = 1'b1;
    bus.master_addr = 32'h0; bus.master_write = 16'h0;
    bus.master_uds = 1'b0;   bus.master_lds = 1'b0;
    bus.slave1_read = 16'h4E71; bus.slave2_read = 16'h1234; bus.slave3_read = 16'h00A5;
    bus.slave1_ack = 1'b0; bus.slave2_ack = 1'b0; bus.slave3_ack = 1'b0;

    // During reset: strobes follow inputs, master_ack held low even on unmapped access
    repeat (2) @(posedge clk);
    @(negedge clk);
    bus.master_addr = 32'h00F80000; bus.master_uds = 1'b1;
    repeat (2) @(posedge clk);
    #1 check("rst_ack", bus.master_ack, 1'b0);
    check("rst_rd", bus.master_read, 16'hFFFF);
    @(negedge clk);
    bus.master_uds = 1'b0;
    reset_n = 1'b0;
    @(posedge clk); #1;

    run_cycle("s1_rd",     32'h00000100, 1, 1, 16'h0000,  3, 3'b001, 16'h4E71,   3);
    run_cycle("s2_wr",     32'h00F00003, 0, 1, 16'h0041,  0, 3'b010, 16'h1234,   0);
    run_cycle("s3_rd",     32'h00F00100, 1, 1, 16'h0000,  0, 3'b100, 16'h00A5,   0);
    run_cycle("unmap",     32'h00F80000, 1, 1, 16'h0000, -1, 3'b000, 16'hFFFF,   1);
    run_cycle("unmap_200", 32'h00F00200, 1, 0, 16'h5A5A, -1, 3'b000, 16'hFFFF,   1);
    run_cycle("s1_top",    32'hAB0EFFFE, 1, 0, 16'h1111,  2, 3'b001, 16'h4E71,   2);
    run_cycle("s2_top",    32'h00F000FF, 0, 1, 16'hBEEF,  1, 3'b010, 16'h1234,   1);
    run_cycle("s3_top",    32'h00F001FF, 1, 1, 16'h2222,  5, 3'b100, 16'h00A5,   5);
    run_cycle("tmo_s1",    32'h00001000, 1, 1, 16'h0000, -1, 3'b001, 16'hFFFF, 256);
    run_cycle("tmo_s2",    32'h00F00010, 1, 0, 16'h0000, -1, 3'b010, 16'hFFFF, 256);

    // Unselected slave acks must not terminate a slave1 cycle
    @(negedge clk);
    bus.slave2_ack = 1'b1; bus.slave3_ack = 1'b1;
    run_cycle("noise_s1",  32'h00000200, 1, 1, 16'h0000,  2, 3'b001, 16'h4E71,   2);

    // Spurious ack while idle
    @(negedge clk);
    bus.slave2_ack = 1'b1;
    #1 check("idle_ack_comb", bus.master_ack, 1'b0);
    @(posedge clk); #1 check("idle_ack_reg", bus.master_ack, 1'b0);
    @(negedge clk);
    bus.slave2_ack = 1'b0;

    // Reset during an acked unmapped cycle drops ack immediately
    @(negedge clk);
    bus.master_addr = 32'h00FF0000; bus.master_uds = 1'b1; bus.master_lds = 1'b1;
    @(posedge clk); #1 check("rstmid_ack_before", bus.master_ack, 1'b1);
    @(negedge clk);
    reset_n = 1'b1;
    #1 check("rstmid_ack_now", bus.master_ack, 1'b0);
    bus.master_uds = 1'b0; bus.master_lds = 1'b0;
    @(negedge clk);
    reset_n = 1'b0;
    run_cycle("post_rst_s3", 32'h00F00104, 1, 1, 16'h0000, 0, 3'b100, 16'h00A5, 0);

    // Reset during a pending timeout clears the wait counter
    sb_q.push_back('{rd: 16'hFFFF, lat: 256});
    @(negedge clk);
    bus.master_addr = 32'h00002000; bus.master_uds = 1'b1; bus.master_lds = 1'b1;
    repeat (100) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    #1 check("rsttmo_ack", bus.master_ack, 1'b0);
    check("rsttmo_stb", bus.slave1_uds, 1'b1);
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    wait_ack(-1, 3'b001, n, seen);
    check("rsttmo_seen", seen, 1'b1);
    e = sb_q.pop_front();
    check("rsttmo_lat", n, e.lat);
    check("rsttmo_rd", bus.master_read, e.rd);
    drop_cycle("rsttmo");

    check("sb_empty", sb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
